// File: rtl/wb_arbiter_if.sv
// Bundle of the writeback arbiter's bus signals: ex results, load returns, load issue,
// pending scoreboard and the register-file write port.
interface wb_arbiter_if #(
    parameter int FIFO_DEPTH = 4
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             i_ex_we;
    logic [4:0]       i_ex_w_addr;
    logic [31:0]      i_ex_w_data;
    logic             i_ld_valid;
    logic [4:0]       i_ld_addr;
    logic [31:0]      i_ld_data;
    logic             o_ld_ready;
    logic             i_ld_issue;
    logic [4:0]       i_ld_issue_addr;
    logic [31:0]      o_pending;
    logic             o_we;
    logic [4:0]       o_w_addr;
    logic [31:0]      o_w_data;
    logic [CNT_W-1:0] o_fifo_count;

    // Upstream stages (ex, load/store unit, id) drive the requests.
    modport master (
        output i_ex_we, i_ex_w_addr, i_ex_w_data,
        output i_ld_valid, i_ld_addr, i_ld_data,
        output i_ld_issue, i_ld_issue_addr,
        input  o_ld_ready, o_pending, o_we, o_w_addr, o_w_data, o_fifo_count
    );

    modport slave (
        input  i_ex_we, i_ex_w_addr, i_ex_w_data,
        input  i_ld_valid, i_ld_addr, i_ld_data,
        input  i_ld_issue, i_ld_issue_addr,
        output o_ld_ready, o_pending, o_we, o_w_addr, o_w_data, o_fifo_count
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ex results and load returns onto the single register-file
// write port, buffers losing loads in a small FIFO and tracks pending load destinations.
module wb_arbiter #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        i_Clk,
    input  logic        i_reset,
    wb_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } ld_entry_t;

    ld_entry_t        fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      pending_q, pending_d;
    logic             we_q, we_d;
    logic [4:0]       w_addr_q, w_addr_d;
    logic [31:0]      w_data_q, w_data_d;

    logic      ld_ready;
    logic      ld_accept;
    logic      ex_write;
    logic      fifo_empty;
    logic      pop;
    logic      bypass;
    logic      push;
    ld_entry_t head;

    // Ready looks only at the registered count, so a full FIFO refuses even while popping.
    assign ld_ready = !i_reset && (count_q < DEPTH_C);

    always_comb begin
        ex_write   = bus.i_ex_we && (bus.i_ex_w_addr != 5'd0);
        fifo_empty = (count_q == '0);
        ld_accept  = bus.i_ld_valid && ld_ready;
        head       = fifo_q[rd_ptr_q];
        pop        = !ex_write && !fifo_empty;
        bypass     = !ex_write && fifo_empty && ld_accept && (bus.i_ld_addr != 5'd0);
        push       = ld_accept && (bus.i_ld_addr != 5'd0) && !bypass;
    end

    // Write-port selection and scoreboard update.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        we_d      = 1'b0;
        w_addr_d  = w_addr_q;
        w_data_d  = w_data_q;
        pending_d = pending_q;

        if (ex_write) begin
            we_d     = 1'b1;
            w_addr_d = bus.i_ex_w_addr;
            w_data_d = bus.i_ex_w_data;
        end else if (pop) begin
            we_d                 = 1'b1;
            w_addr_d             = head.addr;
            w_data_d             = head.data;
            pending_d[head.addr] = 1'b0;
        end else if (bypass) begin
            we_d                     = 1'b1;
            w_addr_d                 = bus.i_ld_addr;
            w_data_d                 = bus.i_ld_data;
            pending_d[bus.i_ld_addr] = 1'b0;
        end

        // A newly issued load re-arms the bit even if its previous load completes now.
        if (bus.i_ld_issue && (bus.i_ld_issue_addr != 5'd0)) begin
            pending_d[bus.i_ld_issue_addr] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_comb begin
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state is updated only with non-blocking assignments so every flop
    // samples the pre-edge value of the others.
    always_ff @(posedge i_Clk) begin
        if (i_reset) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            pending_q <= '0;
            we_q      <= 1'b0;
            w_addr_q  <= '0;
            w_data_q  <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            we_q      <= we_d;
            w_addr_q  <= w_addr_d;
            w_data_q  <= w_data_d;
        end
    end

    // NOTE: the FIFO storage is deliberately not reset; the count and pointers alone
    // decide which entries are valid, and no push can happen while reset is asserted.
    always_ff @(posedge i_Clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= '{addr: bus.i_ld_addr, data: bus.i_ld_data};
        end
    end

    assign bus.o_ld_ready   = ld_ready;
    assign bus.o_pending    = pending_q;
    assign bus.o_we         = we_q;
    assign bus.o_w_addr     = w_addr_q;
    assign bus.o_w_data     = w_data_q;
    assign bus.o_fifo_count = count_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vector table, hand-written multi-cycle
// sequences, then random traffic against a queue-based reference model.
module tb_wb_arbiter;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    wb_arbiter_if #(.FIFO_DEPTH(DEPTH)) bus ();
    wb_arbiter #(.FIFO_DEPTH(DEPTH)) dut (.i_Clk(clk), .i_reset(rst), .bus(bus));

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d required 0 pending", n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (queue of accepted loads) ----------------
    typedef struct packed { logic [4:0] a; logic [31:0] d; } ld_t;
    ld_t         mq[$];
    logic [31:0] m_pend = '0;
    logic        m_we   = 1'b0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;

    task automatic model_step();
        bit acc, wrote_ld;
        ld_t h;
        if (rst) begin
            mq.delete();
            m_pend = '0; m_we = 1'b0; m_addr = '0; m_data = '0;
            return;
        end
        acc      = bus.i_ld_valid && (mq.size() < DEPTH);
        wrote_ld = 1'b0;
        m_we     = 1'b0;
        if (bus.i_ex_we && bus.i_ex_w_addr != 0) begin
            m_we = 1'b1; m_addr = bus.i_ex_w_addr; m_data = bus.i_ex_w_data;
        end else if (mq.size() > 0) begin
            h = mq.pop_front();
            m_we = 1'b1; m_addr = h.a; m_data = h.d;
            m_pend[h.a] = 1'b0;
        end else if (acc && bus.i_ld_addr != 0) begin
            m_we = 1'b1; m_addr = bus.i_ld_addr; m_data = bus.i_ld_data;
            m_pend[bus.i_ld_addr] = 1'b0;
            wrote_ld = 1'b1;
        end
        if (acc && bus.i_ld_addr != 0 && !wrote_ld)
            mq.push_back('{a: bus.i_ld_addr, d: bus.i_ld_data});
        if (bus.i_ld_issue && bus.i_ld_issue_addr != 0)
            m_pend[bus.i_ld_issue_addr] = 1'b1;
        m_pend[0] = 1'b0;
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic idle_inputs();
        bus.i_ex_we = 0; bus.i_ex_w_addr = 0; bus.i_ex_w_data = 0;
        bus.i_ld_valid = 0; bus.i_ld_addr = 0; bus.i_ld_data = 0;
        bus.i_ld_issue = 0; bus.i_ld_issue_addr = 0;
    endtask

    task automatic check_model(input int n);
        check($sformatf("rnd%0d_we", n), bus.o_we, m_we);
        check($sformatf("rnd%0d_addr", n), bus.o_w_addr, m_addr);
        check($sformatf("rnd%0d_data", n), bus.o_w_data, m_data);
        check($sformatf("rnd%0d_pend", n), bus.o_pending, m_pend);
        check($sformatf("rnd%0d_cnt", n), bus.o_fifo_count, mq.size());
        check($sformatf("rnd%0d_rdy", n), bus.o_ld_ready, !rst && (mq.size() < DEPTH));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic rst, ex_we; logic [4:0] ex_a; logic [31:0] ex_d;
        logic ld_v; logic [4:0] ld_a; logic [31:0] ld_d;
        logic iss; logic [4:0] iss_a;
        logic e_we; logic [4:0] e_a; logic [31:0] e_d; logic [31:0] e_pend; int e_cnt; logic e_rdy;
    } vec_t;

    function automatic vec_t mk(logic r, logic xw, logic [4:0] xa, logic [31:0] xd,
                                logic lv, logic [4:0] la, logic [31:0] ld,
                                logic is, logic [4:0] ia,
                                logic ew, logic [4:0] ea, logic [31:0] ed,
                                logic [31:0] ep, int ec, logic er);
        vec_t v;
        v.rst = r; v.ex_we = xw; v.ex_a = xa; v.ex_d = xd;
        v.ld_v = lv; v.ld_a = la; v.ld_d = ld; v.iss = is; v.iss_a = ia;
        v.e_we = ew; v.e_a = ea; v.e_d = ed; v.e_pend = ep; v.e_cnt = ec; v.e_rdy = er;
        return v;
    endfunction

    vec_t tbl[17];

    initial begin
        idle_inputs();
        //             rst ex  exa exd         ldv lda ldd           iss ia   ewe ea  ed            pend         cnt rdy
        tbl[0]  = mk(1, 0, 0, 0,            0, 0,  0,            0, 0,   0, 0,  0,            32'h0,       0, 0);
        tbl[1]  = mk(0, 0, 0, 0,            0, 0,  0,            1, 5,   0, 0,  0,            32'h20,      0, 1);
        tbl[2]  = mk(0, 0, 0, 0,            0, 0,  0,            0, 0,   0, 0,  0,            32'h20,      0, 1);
        tbl[3]  = mk(0, 0, 0, 0,            0, 0,  0,            0, 0,   0, 0,  0,            32'h20,      0, 1);
        tbl[4]  = mk(0, 0, 0, 0,            1, 5,  32'hDEADBEEF, 0, 0,   1, 5,  32'hDEADBEEF, 32'h0,       0, 1);
        tbl[5]  = mk(0, 1, 3, 32'h11,       1, 7,  32'h22,       0, 0,   1, 3,  32'h11,       32'h0,       1, 1);
        tbl[6]  = mk(0, 0, 0, 0,            0, 0,  0,            0, 0,   1, 7,  32'h22,       32'h0,       0, 1);
        tbl[7]  = mk(0, 1, 0, 32'h99,       0, 0,  0,            0, 0,   0, 7,  32'h22,       32'h0,       0, 1);
        tbl[8]  = mk(0, 0, 0, 0,            1, 0,  32'h55,       0, 0,   0, 7,  32'h22,       32'h0,       0, 1);
        tbl[9]  = mk(0, 0, 0, 0,            0, 0,  0,            1, 0,   0, 7,  32'h22,       32'h0,       0, 1);
        tbl[10] = mk(0, 0, 0, 0,            0, 0,  0,            1, 9,   0, 7,  32'h22,       32'h200,     0, 1);
        tbl[11] = mk(0, 0, 0, 0,            1, 9,  32'h99,       1, 9,   1, 9,  32'h99,       32'h200,     0, 1);
        tbl[12] = mk(0, 0, 0, 0,            1, 9,  32'hAB,       0, 0,   1, 9,  32'hAB,       32'h0,       0, 1);
        tbl[13] = mk(0, 0, 0, 0,            0, 0,  0,            1, 12,  0, 9,  32'hAB,       32'h1000,    0, 1);
        tbl[14] = mk(0, 1, 1, 32'h1,        1, 12, 32'hC,        0, 0,   1, 1,  32'h1,        32'h1000,    1, 1);
        tbl[15] = mk(0, 0, 0, 0,            0, 0,  0,            0, 0,   1, 12, 32'hC,        32'h0,       0, 1);
        tbl[16] = mk(0, 0, 4, 32'h77,       0, 0,  0,            0, 0,   0, 12, 32'hC,        32'h0,       0, 1);

        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            rst = tbl[i].rst;
            bus.i_ex_we = tbl[i].ex_we; bus.i_ex_w_addr = tbl[i].ex_a; bus.i_ex_w_data = tbl[i].ex_d;
            bus.i_ld_valid = tbl[i].ld_v; bus.i_ld_addr = tbl[i].ld_a; bus.i_ld_data = tbl[i].ld_d;
            bus.i_ld_issue = tbl[i].iss; bus.i_ld_issue_addr = tbl[i].iss_a;
            cycle();
            check($sformatf("vec%0d_we", i), bus.o_we, tbl[i].e_we);
            check($sformatf("vec%0d_addr", i), bus.o_w_addr, tbl[i].e_a);
            check($sformatf("vec%0d_data", i), bus.o_w_data, tbl[i].e_d);
            check($sformatf("vec%0d_pend", i), bus.o_pending, tbl[i].e_pend);
            check($sformatf("vec%0d_cnt", i), bus.o_fifo_count, tbl[i].e_cnt);
            check($sformatf("vec%0d_rdy", i), bus.o_ld_ready, tbl[i].e_rdy);
        end
        idle_inputs();

        // ---- full FIFO: ex x1..x4 every cycle with loads x8.. behind them ----
        for (int c = 0; c < 4; c++) begin
            bus.i_ex_we = 1; bus.i_ex_w_addr = 5'(c + 1); bus.i_ex_w_data = 32'h100 + c;
            bus.i_ld_valid = 1; bus.i_ld_addr = 5'(8 + c); bus.i_ld_data = 32'h200 + c;
            cycle();
            check($sformatf("full%0d_addr", c), bus.o_w_addr, c + 1);
            check($sformatf("full%0d_cnt", c), bus.o_fifo_count, c + 1);
        end
        check("full_rdy_low", bus.o_ld_ready, 0);
        bus.i_ex_we = 0; bus.i_ex_w_addr = 0;
        bus.i_ld_valid = 1; bus.i_ld_addr = 12; bus.i_ld_data = 32'h204;
        cycle();
        check("full_stall_addr", bus.o_w_addr, 8);
        check("full_stall_data", bus.o_w_data, 32'h200);
        check("full_stall_cnt", bus.o_fifo_count, 3);
        check("full_stall_rdy", bus.o_ld_ready, 1);
        cycle();
        check("full_accept_addr", bus.o_w_addr, 9);
        check("full_accept_cnt", bus.o_fifo_count, 3);
        bus.i_ld_valid = 0; bus.i_ld_addr = 0;
        for (int k = 2; k < 5; k++) begin
            cycle();
            check($sformatf("drain%0d_we", k), bus.o_we, 1);
            check($sformatf("drain%0d_addr", k), bus.o_w_addr, 8 + k);
            check($sformatf("drain%0d_data", k), bus.o_w_data, 32'h200 + k);
            check($sformatf("drain%0d_cnt", k), bus.o_fifo_count, 4 - k);
        end
        idle_inputs();

        // ---- reset in the middle of traffic with three loads queued ----
        for (int c = 0; c < 3; c++) begin
            bus.i_ld_issue = 1; bus.i_ld_issue_addr = 5'(20 + c);
            cycle();
        end
        bus.i_ld_issue = 0;
        check("rst_pre_pend", bus.o_pending, 32'h0070_0000);
        for (int c = 0; c < 3; c++) begin
            bus.i_ex_we = 1; bus.i_ex_w_addr = 1; bus.i_ex_w_data = 32'h1;
            bus.i_ld_valid = 1; bus.i_ld_addr = 5'(20 + c); bus.i_ld_data = 32'h300 + c;
            cycle();
        end
        check("rst_pre_cnt", bus.o_fifo_count, 3);
        check("rst_pre_pend2", bus.o_pending, 32'h0070_0000);
        rst = 1;
        bus.i_ex_w_addr = 2; bus.i_ld_addr = 23; bus.i_ld_issue = 1; bus.i_ld_issue_addr = 24;
        for (int c = 0; c < 2; c++) begin
            cycle();
            check($sformatf("rst%0d_we", c), bus.o_we, 0);
            check($sformatf("rst%0d_addr", c), bus.o_w_addr, 0);
            check($sformatf("rst%0d_data", c), bus.o_w_data, 0);
            check($sformatf("rst%0d_cnt", c), bus.o_fifo_count, 0);
            check($sformatf("rst%0d_pend", c), bus.o_pending, 0);
            check($sformatf("rst%0d_rdy", c), bus.o_ld_ready, 0);
        end
        rst = 0;
        idle_inputs();
        cycle();
        check("post_rst_we", bus.o_we, 0);
        check("post_rst_cnt", bus.o_fifo_count, 0);
        check("post_rst_pend", bus.o_pending, 0);
        check("post_rst_rdy", bus.o_ld_ready, 1);

        // ---- randomized traffic against the reference model ----
        for (int n = 0; n < 3000; n++) begin
            rst                 = ($urandom_range(0, 149) == 0);
            bus.i_ex_we         = ($urandom_range(0, 99) < 35);
            bus.i_ex_w_addr     = 5'($urandom);
            bus.i_ex_w_data     = $urandom;
            bus.i_ld_valid      = ($urandom_range(0, 99) < 50);
            bus.i_ld_addr       = ($urandom_range(0, 15) == 0) ? 5'd0 : 5'($urandom);
            bus.i_ld_data       = $urandom;
            bus.i_ld_issue      = ($urandom_range(0, 99) < 30);
            bus.i_ld_issue_addr = 5'($urandom);
            cycle();
            check_model(n);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
